tl_a_channel_arbiter: RTL and testbench

// - Shares one TileLink-UL A channel between N_REQ requesters; routes D-channel responses back by source.
// - Round-robin arbitration with burst locking; multi-beat Put holds the grant until its last beat.
// - Per-requester in-flight limit.
// - Sits between the core-side masters and the single port checked by the TL protocol monitor.

---
 rtl/tl_a_channel_arbiter_if.sv | 47 ++++
 rtl/tl_a_channel_arbiter.sv | 131 +++++++++++++
 tb/tb_tl_a_channel_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tl_a_channel_arbiter_if.sv
// A/D channel bundle between N_REQ TileLink-UL requesters and one shared port.
// The arbiter uses the slave modport; whoever drives the requesters and the downstream port uses master.
interface tl_a_channel_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 31,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 4
);
  localparam int SW = SRC_W + $clog2(N_REQ);

  logic [N_REQ-1:0]             in_a_valid;
  logic [N_REQ-1:0]             in_a_ready;
  logic [N_REQ-1:0][2:0]        in_a_opcode;
  logic [N_REQ-1:0][2:0]        in_a_size;
  logic [N_REQ-1:0][SRC_W-1:0]  in_a_source;
  logic [N_REQ-1:0][ADDR_W-1:0] in_a_address;
  logic [N_REQ-1:0][DATA_W-1:0] in_a_data;

  logic              out_a_valid;
  logic              out_a_ready;
  logic [2:0]        out_a_opcode;
  logic [2:0]        out_a_size;
  logic [SW-1:0]     out_a_source;
  logic [ADDR_W-1:0] out_a_address;
  logic [DATA_W-1:0] out_a_data;

  logic              in_d_valid;
  logic              in_d_ready;
  logic [SW-1:0]     in_d_source;
  logic              in_d_last;
  logic [N_REQ-1:0]  out_d_valid;
  logic [N_REQ-1:0]  out_d_ready;

  modport slave (
    input  in_a_valid, in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_data,
    input  out_a_ready, in_d_valid, in_d_source, in_d_last, out_d_ready,
    output in_a_ready, out_a_valid, out_a_opcode, out_a_size, out_a_source,
    output out_a_address, out_a_data, in_d_ready, out_d_valid
  );

  modport master (
    output in_a_valid, in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_data,
    output out_a_ready, in_d_valid, in_d_source, in_d_last, out_d_ready,
    input  in_a_ready, out_a_valid, out_a_opcode, out_a_size, out_a_source,
    input  out_a_address, out_a_data, in_d_ready, out_d_valid
  );
endinterface

// File: rtl/tl_a_channel_arbiter.sv
// Round-robin TL-UL A-channel arbiter with multi-beat Put locking, per-requester
// in-flight limits, and D-channel routing by the top source bits.
module tl_a_channel_arbiter #(
  parameter int N_REQ        = 2,
  parameter int ADDR_W       = 31,
  parameter int DATA_W       = 32,
  parameter int SRC_W        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clock,
  input  logic reset,
  tl_a_channel_arbiter_if.slave bus
);
  localparam int IW     = $clog2(N_REQ);
  localparam int SW     = SRC_W + IW;
  localparam int LOG_BB = $clog2(DATA_W / 8);
  localparam int CW     = 4;
  localparam int BW     = 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        ptr, ptr_nx, lock_idx, lock_idx_nx, grant, cand;
  logic [BW-1:0]        beats_left, beats_left_nx, beats;
  logic [N_REQ-1:0][CW-1:0] cnt;
  logic [N_REQ-1:0]     eligible, inc, dec, a_rdy, d_vld;
  logic                 found, a_valid, a_fire, d_fire;
  logic [2:0]           g_opc, g_size;
  logic [IW-1:0]        d_idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_elig
    assign eligible[i] = bus.in_a_valid[i] & (cnt[i] != CW'(MAX_INFLIGHT));
  end

  // While locked the burst owner keeps the port regardless of its in-flight count.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + IW'(k);
      if (!found && eligible[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    if (state == LOCKED) grant = lock_idx;
  end

  assign a_valid = !reset && ((state == LOCKED) ? bus.in_a_valid[grant] : eligible[grant]);
  assign a_fire  = a_valid & bus.out_a_ready;

  assign g_opc  = bus.in_a_opcode[grant];
  assign g_size = bus.in_a_size[grant];
  assign beats  = ((g_opc == 3'd0 || g_opc == 3'd1) && g_size > 3'(LOG_BB))
                  ? (BW'(1) << (g_size - 3'(LOG_BB))) : BW'(1);

  always_comb begin
    a_rdy        = '0;
    a_rdy[grant] = a_fire;
  end

  assign bus.in_a_ready    = a_rdy;
  assign bus.out_a_valid   = a_valid;
  assign bus.out_a_opcode  = g_opc;
  assign bus.out_a_size    = g_size;
  assign bus.out_a_source  = {grant, bus.in_a_source[grant]};
  assign bus.out_a_address = bus.in_a_address[grant];
  assign bus.out_a_data    = bus.in_a_data[grant];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      lock_idx   <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      lock_idx   <= lock_idx_nx;
      beats_left <= beats_left_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    lock_idx_nx   = lock_idx;
    beats_left_nx = beats_left;
    case (state)
      IDLE: if (a_fire) begin
        if (beats > BW'(1)) begin
          state_nx      = LOCKED;
          lock_idx_nx   = grant;
          beats_left_nx = beats - BW'(1);
        end else begin
          ptr_nx = grant + IW'(1);
        end
      end
      LOCKED: if (a_fire) begin
        beats_left_nx = beats_left - BW'(1);
        if (beats_left == BW'(1)) begin
          state_nx = IDLE;
          ptr_nx   = grant + IW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign d_idx = bus.in_d_source[SW-1 -: IW];
  assign bus.in_d_ready = bus.out_d_ready[d_idx];
  assign d_fire = bus.in_d_valid & bus.in_d_ready & bus.in_d_last;

  always_comb begin
    d_vld        = '0;
    d_vld[d_idx] = bus.in_d_valid;
  end
  assign bus.out_d_valid = d_vld;

  // Only the first beat of a request counts as a new outstanding transaction.
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    assign inc[i] = a_fire & (state == IDLE) & (grant == IW'(i));
    assign dec[i] = d_fire & (d_idx == IW'(i));
    always_ff @(posedge clock) begin
      if (reset)                                cnt[i] <= '0;
      else if (inc[i] && !dec[i])               cnt[i] <= cnt[i] + CW'(1);
      else if (dec[i] && !inc[i] && cnt[i] != 0) cnt[i] <= cnt[i] - CW'(1);
    end
  end
endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Directed bench for tl_a_channel_arbiter: round robin, burst lock, in-flight limit,
// D routing/counting, backpressure mid-burst and reset mid-burst.
module tb_tl_a_channel_arbiter;
  localparam int SW = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  tl_a_channel_arbiter_if bus ();

  tl_a_channel_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] opc, input logic [2:0] sz);
    bus.in_a_valid[i]   = v;
    bus.in_a_opcode[i]  = opc;
    bus.in_a_size[i]    = sz;
    bus.in_a_source[i]  = 4'(i + 3);
    bus.in_a_address[i] = 31'(32'h100 * (i + 1));
    bus.in_a_data[i]    = 32'hA0 + 32'(i);
  endtask

  task automatic clear_all();
    bus.in_a_valid  = '0;
    bus.out_a_ready = 1'b1;
    bus.in_d_valid  = 1'b0;
    bus.in_d_source = '0;
    bus.in_d_last   = 1'b0;
    bus.out_d_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_all();
    set_req(0, 1'b1, 3'd4, 3'd2);
    set_req(1, 1'b1, 3'd4, 3'd2);
    tick(); tick(); #1;
    chk("rst_a_ready", 64'(bus.in_a_ready), 64'd0);
    chk("rst_a_valid", 64'(bus.out_a_valid), 64'd0);
    chk("rst_cnt0", 64'(dut.cnt[0]), 64'd0);
    chk("rst_state", 64'(dut.state), 64'd0);

    // Round robin on single-beat Gets: 0,1,0,1
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_src_msb", 64'(bus.out_a_source[SW-1]), 64'(k % 2));
      chk("rr_a_ready", 64'(bus.in_a_ready), (k % 2) ? 64'd2 : 64'd1);
      tick();
    end
    #1;
    chk("rr_cnt0", 64'(dut.cnt[0]), 64'd2);
    chk("rr_cnt1", 64'(dut.cnt[1]), 64'd2);

    // 4-beat PutFull from req0 holds the port against req1
    clear_all(); do_reset();
    set_req(0, 1'b1, 3'd0, 3'd4);
    set_req(1, 1'b1, 3'd4, 3'd2);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("burst_src_msb", 64'(bus.out_a_source[SW-1]), 64'd0);
      chk("burst_a_ready", 64'(bus.in_a_ready), 64'd1);
      tick();
      if (b < 3) chk("burst_locked", 64'(dut.state), 64'd1);
    end
    #1;
    chk("burst_then_req1", 64'(bus.out_a_source[SW-1]), 64'd1);
    chk("burst_unlocked", 64'(dut.state), 64'd0);
    chk("burst_cnt0", 64'(dut.cnt[0]), 64'd1);

    // In-flight limit on req1
    clear_all(); do_reset();
    set_req(1, 1'b1, 3'd4, 3'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lim_accept", 64'(bus.in_a_ready), 64'd2);
      tick();
    end
    #1;
    chk("lim_block_ready", 64'(bus.in_a_ready), 64'd0);
    chk("lim_block_valid", 64'(bus.out_a_valid), 64'd0);
    chk("lim_cnt1", 64'(dut.cnt[1]), 64'd4);
    bus.in_d_valid  = 1'b1;
    bus.in_d_source = 5'h13;
    bus.in_d_last   = 1'b1;
    bus.out_d_ready = 2'b10;
    #1;
    chk("d_route1", 64'(bus.out_d_valid), 64'd2);
    chk("d_ready1", 64'(bus.in_d_ready), 64'd1);
    chk("lim_still_block", 64'(bus.in_a_ready), 64'd0);
    tick();
    bus.in_d_valid = 1'b0;
    #1;
    chk("lim_unblock", 64'(bus.in_a_ready), 64'd2);
    chk("lim_cnt1_dec", 64'(dut.cnt[1]), 64'd3);

    // Simultaneous inc/dec on req0, dec at zero, D without last
    clear_all(); do_reset();
    set_req(0, 1'b1, 3'd4, 3'd2);
    tick(); tick(); #1;
    chk("id_cnt0_pre", 64'(dut.cnt[0]), 64'd2);
    bus.in_d_valid  = 1'b1;
    bus.in_d_source = 5'h03;
    bus.in_d_last   = 1'b1;
    bus.out_d_ready = 2'b01;
    #1;
    chk("d_route0", 64'(bus.out_d_valid), 64'd1);
    chk("id_a_ready", 64'(bus.in_a_ready), 64'd1);
    tick();
    bus.in_a_valid = '0;
    bus.in_d_valid = 1'b0;
    #1;
    chk("id_cnt0_same", 64'(dut.cnt[0]), 64'd2);
    bus.in_d_valid  = 1'b1;
    bus.in_d_source = 5'h10;
    bus.out_d_ready = 2'b10;
    tick();
    bus.in_d_valid  = 1'b1;
    bus.in_d_source = 5'h03;
    bus.in_d_last   = 1'b0;
    bus.out_d_ready = 2'b01;
    #1;
    chk("dec_at_zero", 64'(dut.cnt[1]), 64'd0);
    tick();
    bus.in_d_valid = 1'b0;
    #1;
    chk("d_not_last", 64'(dut.cnt[0]), 64'd2);

    // Backpressure and valid drop mid-burst
    clear_all(); do_reset();
    set_req(0, 1'b1, 3'd0, 3'd4);
    set_req(1, 1'b1, 3'd4, 3'd2);
    tick();
    bus.out_a_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_beats_left", 64'(dut.beats_left), 64'd3);
      chk("bp_locked", 64'(dut.state), 64'd1);
      chk("bp_valid", 64'(bus.out_a_valid), 64'd1);
      chk("bp_src_msb", 64'(bus.out_a_source[SW-1]), 64'd0);
      chk("bp_addr", 64'(bus.out_a_address), 64'h100);
      chk("bp_data", 64'(bus.out_a_data), 64'hA0);
      chk("bp_a_ready", 64'(bus.in_a_ready), 64'd0);
      tick();
    end
    bus.in_a_valid[0] = 1'b0;
    bus.out_a_ready   = 1'b1;
    #1;
    chk("drop_valid", 64'(bus.out_a_valid), 64'd0);
    chk("drop_a_ready", 64'(bus.in_a_ready), 64'd0);
    tick(); #1;
    chk("drop_locked", 64'(dut.state), 64'd1);
    chk("drop_beats_left", 64'(dut.beats_left), 64'd3);
    bus.in_a_valid[0] = 1'b1;
    tick(); tick(); tick(); #1;
    chk("bp_done_state", 64'(dut.state), 64'd0);
    chk("bp_done_req1", 64'(bus.out_a_source[SW-1]), 64'd1);

    // Reset after beat 2 of 4 discards the burst
    clear_all(); do_reset();
    set_req(0, 1'b1, 3'd0, 3'd4);
    set_req(1, 1'b1, 3'd4, 3'd2);
    tick(); tick(); #1;
    chk("mr_beats_left", 64'(dut.beats_left), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_a_valid[0] = 1'b0;
    #1;
    chk("mr_state", 64'(dut.state), 64'd0);
    chk("mr_cnt0", 64'(dut.cnt[0]), 64'd0);
    chk("mr_valid", 64'(bus.out_a_valid), 64'd1);
    chk("mr_req1", 64'(bus.out_a_source[SW-1]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
